// File: rtl/song_sequencer_pkg.sv
// Shared constants, ROM field layout and state encoding
// for the song sequencer and its step timer.
package song_sequencer_pkg;

   localparam int TONE_W = 4;
   localparam int DUR_W = 4;
   localparam int ROM_W = 20;
   localparam logic [TONE_W-1:0] TONE_REST = 4'd0;

   localparam int DUR_LSB = 16;
   localparam int TONE0_LSB = 0;
   localparam int TONE1_LSB = 4;
   localparam int TONE2_LSB = 8;
   localparam int TONE3_LSB = 12;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FETCH = 2'd1,
      LATCH = 2'd2,
      HOLD  = 2'd3
   } seq_state_t;

   function automatic logic [DUR_W-1:0] dur_of(
      input logic [ROM_W-1:0] d
   );
      return d[DUR_LSB +: DUR_W];
   endfunction

   function automatic logic [TONE_W-1:0] tone_of(
      input logic [4*TONE_W-1:0] t,
      input int lsb
   );
      return t[lsb +: TONE_W];
   endfunction

endpackage

// File: rtl/song_sequencer_if.sv
// Note ROM bus: registered address out, data back one cycle later.
interface song_sequencer_if #(
   parameter int ADDR_W = 6
) ();

   logic [ADDR_W-1:0] rom_addr;
   logic [song_sequencer_pkg::ROM_W-1:0] rom_data;

   modport master (
      output rom_addr,
      input  rom_data
   );

   modport slave (
      input  rom_addr,
      output rom_data
   );

endinterface

// File: rtl/song_sequencer_step_timer.sv
// Tempo prescaler: counts 0..PERIOD-1 while enabled, ticks on the wrap.
module step_timer #(
   parameter logic [31:0] PERIOD = 32'd3_072_000
) (
   input  logic clk,
   input  logic reset,
   input  logic clear,
   input  logic en,
   output logic tick
);

   logic [31:0] cnt;
   logic wrap;

   assign wrap = (cnt == PERIOD - 32'd1);
   assign tick = en && !clear && wrap;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt <= '0;
      end else if (clear) begin
         cnt <= '0;
      end else if (en) begin
         cnt <= wrap ? '0 : cnt + 32'd1;
      end
   end

endmodule

// File: rtl/song_sequencer.sv
// 4-voice song player: walks the note ROM at a fixed tempo with
// per-note durations, play/stop/loop control and done signalling.
module song_sequencer
   import song_sequencer_pkg::*;
#(
   parameter logic [31:0] CLK_SPEED = 32'd12_288_000,
   parameter logic [31:0] STEP_RATE = 32'd4,
   parameter int ADDR_W = 6
) (
   input  logic clk,
   input  logic reset,
   input  logic play,
   input  logic stop,
   input  logic loop_en,
   song_sequencer_if.master rom,
   output logic [TONE_W-1:0] tone0,
   output logic [TONE_W-1:0] tone1,
   output logic [TONE_W-1:0] tone2,
   output logic [TONE_W-1:0] tone3,
   output logic [ADDR_W-1:0] note_index,
   output logic busy,
   output logic step_pulse,
   output logic done
);

   localparam logic [31:0] PERIOD = CLK_SPEED / STEP_RATE;
   localparam logic [ADDR_W-1:0] LAST = '1;

   seq_state_t state, state_n;
   logic [ADDR_W-1:0] index, index_n;
   logic [ADDR_W-1:0] addr;
   logic [DUR_W-1:0] dur_cnt;
   logic [DUR_W-1:0] rom_dur;
   logic [4*TONE_W-1:0] tones;
   logic note_ld, tone_clr, done_n, dec;
   logic in_hold, tick;

   assign rom_dur = dur_of(rom.rom_data);
   assign in_hold = (state == HOLD);
   assign rom.rom_addr = addr;

   assign tone0 = tone_of(tones, TONE0_LSB);
   assign tone1 = tone_of(tones, TONE1_LSB);
   assign tone2 = tone_of(tones, TONE2_LSB);
   assign tone3 = tone_of(tones, TONE3_LSB);

   assign busy = (state != IDLE);
   assign step_pulse = tick;

   step_timer #(
      .PERIOD (PERIOD)
   ) u_timer (
      .clk   (clk),
      .reset (reset),
      .clear (!in_hold),
      .en    (in_hold),
      .tick  (tick)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= IDLE;
         index <= '0;
         addr <= '0;
         note_index <= '0;
         dur_cnt <= '0;
         tones <= '0;
         done <= 1'b0;
      end else begin
         state <= state_n;
         index <= index_n;
         done <= done_n;
         // Address is registered on entry so ROM data lands in LATCH.
         if (state_n == FETCH) begin
            addr <= index_n;
         end
         if (tone_clr) begin
            tones <= {4{TONE_REST}};
         end else if (note_ld) begin
            tones <= rom.rom_data[4*TONE_W-1:0];
            note_index <= index;
         end
         if (note_ld) begin
            dur_cnt <= rom_dur;
         end else if (dec) begin
            dur_cnt <= dur_cnt - DUR_W'(1);
         end
      end
   end

   always_comb begin
      state_n = state;
      index_n = index;
      note_ld = 1'b0;
      tone_clr = 1'b0;
      done_n = 1'b0;
      dec = 1'b0;
      if (stop) begin
         state_n = IDLE;
         tone_clr = 1'b1;
      end else if (play) begin
         state_n = FETCH;
         index_n = '0;
      end else begin
         unique case (state)
            IDLE: begin
               state_n = IDLE;
            end
            FETCH: begin
               state_n = LATCH;
            end
            LATCH: begin
               if (rom_dur != '0) begin
                  note_ld = 1'b1;
                  state_n = HOLD;
               end else if (loop_en && index != '0) begin
                  index_n = '0;
                  state_n = FETCH;
               end else begin
                  tone_clr = 1'b1;
                  done_n = 1'b1;
                  state_n = IDLE;
               end
            end
            HOLD: begin
               if (tick) begin
                  dec = 1'b1;
                  if (dur_cnt == DUR_W'(1)) begin
                     if (index != LAST) begin
                        index_n = index + ADDR_W'(1);
                        state_n = FETCH;
                     end else if (loop_en) begin
                        index_n = '0;
                        state_n = FETCH;
                     end else begin
                        tone_clr = 1'b1;
                        done_n = 1'b1;
                        state_n = IDLE;
                     end
                  end
               end
            end
            default: begin
               state_n = IDLE;
            end
         endcase
      end
   end

endmodule
